// File: rtl/alu_op_arbiter_pkg.sv
// Shared types for the ALU operation arbiter: opcode encoding and the issue tag carried alongside each op.
package alu_arb_pkg;

  localparam int ALU_SEL_W = 3;
  localparam int MAX_REQ_W = 3;

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_SHL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic                 valid;
    logic [MAX_REQ_W-1:0] id;
  } arb_tag_t;

endpackage

// File: rtl/alu_op_arbiter_if.sv
// Requester, ALU and response buses of the arbiter; slave = arbiter side, master = requesters plus ALU.
interface alu_op_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) ();
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0][ALU_SEL_W-1:0] req_sel;
  logic [NUM_REQ-1:0][DATA_W-1:0]    req_a;
  logic [NUM_REQ-1:0][DATA_W-1:0]    req_b;
  logic [ALU_SEL_W-1:0]              alu_sel;
  logic [DATA_W-1:0]                 alu_a;
  logic [DATA_W-1:0]                 alu_b;
  logic                              alu_vld;
  logic [DATA_W-1:0]                 alu_c;
  logic                              alu_z;
  logic                              rsp_valid;
  logic [IDX_W-1:0]                  rsp_id;
  logic [DATA_W-1:0]                 rsp_c;
  logic                              rsp_z;

  modport slave (
    input  req_valid, req_sel, req_a, req_b, alu_c, alu_z,
    output req_ready, alu_sel, alu_a, alu_b, alu_vld,
           rsp_valid, rsp_id, rsp_c, rsp_z
  );

  modport master (
    output req_valid, req_sel, req_a, req_b, alu_c, alu_z,
    input  req_ready, alu_sel, alu_a, alu_b, alu_vld,
           rsp_valid, rsp_id, rsp_c, rsp_z
  );
endinterface

// File: rtl/alu_op_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, circularly; no grant when en=0.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);
  logic           found;
  logic [IDX_W:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // one extra bit so ptr+i can be folded back below NUM_REQ
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (en && !found && req[cand[IDX_W-1:0]]) begin
        found                  = 1'b1;
        gnt[cand[IDX_W-1:0]]   = 1'b1;
        idx                    = cand[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/alu_op_arbiter.sv
// Round-robin sharing of one ALU; issue registered 1 cycle after handshake, response ALU_LAT+2 cycles after; hold stalls grants, responses never stall.
// Optional per-requester grant counters under ALU_ARB_STATS_EN.
module alu_op_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  alu_op_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0] grant_cnt
`endif
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   ptr;
  logic               hs;
  arb_tag_t           tags [ALU_LAT+1];
  arb_tag_t           tag_out;

  // rst_n gates the grant so req_ready reads 0 while reset is held
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr),
    .en  (rst_n & ~hold),
    .gnt (gnt),
    .idx (gidx)
  );

  assign bus.req_ready = gnt;
  assign hs            = |gnt;
  assign tag_out       = tags[ALU_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      bus.alu_vld <= 1'b0;
      bus.alu_sel <= '0;
      bus.alu_a   <= '0;
      bus.alu_b   <= '0;
    end else begin
      bus.alu_vld <= hs;
      if (hs) begin
        bus.alu_sel <= bus.req_sel[gidx];
        bus.alu_a   <= bus.req_a[gidx];
        bus.alu_b   <= bus.req_b[gidx];
        ptr         <= (gidx == IDX_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= ALU_LAT; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{valid: hs, id: MAX_REQ_W'(gidx)};
      for (int i = 1; i <= ALU_LAT; i++) tags[i] <= tags[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_c     <= '0;
      bus.rsp_z     <= 1'b0;
    end else begin
      bus.rsp_valid <= tag_out.valid;
      if (tag_out.valid) begin
        bus.rsp_id <= IDX_W'(tag_out.id);
        bus.rsp_c  <= bus.alu_c;
        bus.rsp_z  <= bus.alu_z;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && grant_cnt[i] != 16'hFFFF) grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_alu_op_arbiter.sv
// Bench for alu_op_arbiter: behavioural ALU, scoreboard of expected responses, vector table and random traffic.
module tb_alu_op_arbiter;
  import alu_arb_pkg::*;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  always #5 clk = ~clk;

  alu_op_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();
`ifdef ALU_ARB_STATS_EN
  logic [N-1:0][15:0] grant_cnt;
`endif

  alu_op_arbiter #(.NUM_REQ(N), .DATA_W(W), .ALU_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hold),
    .bus   (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  function automatic logic [W-1:0] alu_ref(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    case (alu_op_e'(s))
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_NOT: return ~a;
      ALU_SHL: return a << 1;
      default: return W'($signed(a) >>> 1);
    endcase
  endfunction

  // single-stage ALU stand-in
  always @(posedge clk) begin
    bus.alu_c <= alu_ref(bus.alu_sel, bus.alu_a, bus.alu_b);
    bus.alu_z <= (alu_ref(bus.alu_sel, bus.alu_a, bus.alu_b) == '0);
  end

  typedef struct {
    int           id;
    logic [W-1:0] c;
    logic         z;
    int           due;
  } rsp_t;

  typedef struct {
    logic [N-1:0] v;
    logic         h;
    logic [N-1:0] rdy;
  } vec_t;

  rsp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   m_ptr = 0;
  int   stat [N];
  logic         exp_vld;
  logic [2:0]   exp_sel;
  logic [W-1:0] exp_a, exp_b;
  logic [N-1:0][2:0]   s_v;
  logic [N-1:0][W-1:0] a_v, b_v;
  logic [N-1:0]        rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // winner = valid requester at the smallest circular distance from the pointer
  function automatic int model_pick(input logic [N-1:0] v, input logic h, input int p);
    int best = -1;
    int bestd = N;
    if (!h) begin
      for (int i = 0; i < N; i++) begin
        if (v[i] && ((i - p + N) % N) < bestd) begin
          bestd = (i - p + N) % N;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_clear();
    m_ptr = 0; exp_vld = 1'b0; exp_sel = '0; exp_a = '0; exp_b = '0;
    q.delete();
    for (int i = 0; i < N; i++) stat[i] = 0;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      s_v[i] = 3'($urandom_range(0, 7));
      a_v[i] = W'($urandom);
      b_v[i] = W'($urandom);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_alu_vld"},   32'(bus.alu_vld),   32'd0);
    chk({tag, "_alu_sel"},   32'(bus.alu_sel),   32'd0);
    chk({tag, "_alu_a"},     32'(bus.alu_a),     32'd0);
    chk({tag, "_alu_b"},     32'(bus.alu_b),     32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_id"},    32'(bus.rsp_id),    32'd0);
    chk({tag, "_rsp_c"},     32'(bus.rsp_c),     32'd0);
    chk({tag, "_rsp_z"},     32'(bus.rsp_z),     32'd0);
`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk({tag, "_grant_cnt"}, 32'(grant_cnt[i]), 32'd0);
`endif
  endtask

  task automatic check_regs();
    chk("alu_vld", 32'(bus.alu_vld), 32'(exp_vld));
    chk("alu_sel", 32'(bus.alu_sel), 32'(exp_sel));
    chk("alu_a",   32'(bus.alu_a),   32'(exp_a));
    chk("alu_b",   32'(bus.alu_b),   32'(exp_b));
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_id",    32'(bus.rsp_id),    q[0].id);
      chk("rsp_c",     32'(bus.rsp_c),     32'(q[0].c));
      chk("rsp_z",     32'(bus.rsp_z),     32'(q[0].z));
      void'(q.pop_front());
    end else begin
      chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  // one cycle: check registered outputs, drive inputs, check grant, advance model
  task automatic step(input logic [N-1:0] v, input logic h, output logic [N-1:0] seen);
    int   g;
    rsp_t r;
    check_regs();
    bus.req_valid = v; bus.req_sel = s_v; bus.req_a = a_v; bus.req_b = b_v; hold = h;
    #1;
    g    = model_pick(v, h, m_ptr);
    seen = bus.req_ready;
    chk("req_ready", 32'(seen), (g >= 0) ? (32'd1 << g) : 32'd0);
    if (g >= 0) begin
      exp_vld = 1'b1; exp_sel = s_v[g]; exp_a = a_v[g]; exp_b = b_v[g];
      r.id  = g;
      r.c   = alu_ref(s_v[g], a_v[g], b_v[g]);
      r.z   = (r.c == '0);
      r.due = cyc + 2 + LAT;
      q.push_back(r);
      m_ptr = (g + 1) % N;
      stat[g]++;
    end else begin
      exp_vld = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_zero("rst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
  endtask

  vec_t tab [15];

  initial begin
    tab[0]  = '{4'b1111, 1'b0, 4'b1000};
    tab[1]  = '{4'b1111, 1'b0, 4'b0001};
    tab[2]  = '{4'b1111, 1'b0, 4'b0010};
    tab[3]  = '{4'b1111, 1'b0, 4'b0100};
    tab[4]  = '{4'b0011, 1'b0, 4'b0001};
    tab[5]  = '{4'b0011, 1'b0, 4'b0010};
    tab[6]  = '{4'b0011, 1'b0, 4'b0001};
    tab[7]  = '{4'b1111, 1'b1, 4'b0000};
    tab[8]  = '{4'b0000, 1'b0, 4'b0000};
    tab[9]  = '{4'b1001, 1'b0, 4'b1000};
    tab[10] = '{4'b1001, 1'b0, 4'b0001};
    tab[11] = '{4'b0110, 1'b0, 4'b0010};
    tab[12] = '{4'b0110, 1'b0, 4'b0100};
    tab[13] = '{4'b0110, 1'b0, 4'b0010};
    tab[14] = '{4'b1000, 1'b1, 4'b0000};

    model_clear();
    bus.req_valid = '0; bus.req_sel = '0; bus.req_a = '0; bus.req_b = '0;

    // inputs toggling under reset must not leak to outputs
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rand_ops();
      bus.req_valid = N'($urandom); bus.req_sel = s_v; bus.req_a = a_v; bus.req_b = b_v;
      hold = 1'($urandom);
      #1;
      check_zero("inrst");
    end
    @(negedge clk);
    bus.req_valid = '0; hold = 1'b0; rst_n = 1'b1;
    cyc = 0;
    idle(3);

    // single requester: op 0 (add) 5+3 from requester 2
    rand_ops();
    s_v[2] = 3'd0; a_v[2] = 8'd5; b_v[2] = 8'd3;
    step(4'b0100, 1'b0, rdy);
    chk("single_ready", 32'(rdy), 32'h4);
    chk("single_alu_vld", 32'(bus.alu_vld), 32'd1);
    chk("single_alu_a", 32'(bus.alu_a), 32'd5);
    chk("single_alu_b", 32'(bus.alu_b), 32'd3);
    idle(2);
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_rsp_id", 32'(bus.rsp_id), 32'd2);
    chk("single_rsp_c", 32'(bus.rsp_c), 32'd8);
    idle(1);

    for (int k = 0; k < 15; k++) begin
      rand_ops();
      step(tab[k].v, tab[k].h, rdy);
      chk($sformatf("vec%0d_ready", k), 32'(rdy), 32'(tab[k].rdy));
    end
    idle(4);

    // full contention from a clean pointer, then hold in the middle
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      step(4'b1111, 1'b0, rdy);
      chk("rr_order", 32'(rdy), 32'd1 << (k % 4));
    end
    for (int k = 0; k < 6; k++) begin
      rand_ops();
      step(4'b1111, (k < 3), rdy);
      if (k < 3)  chk("hold_ready", 32'(rdy), 32'd0);
      if (k == 3) chk("hold_resume", 32'(rdy), 32'd1);
    end
    idle(4);

    for (int k = 0; k < 400; k++) begin
      rand_ops();
      step(N'($urandom), ($urandom_range(0, 9) == 0), rdy);
    end
    idle(4);
`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("grant_cnt", 32'(grant_cnt[i]), stat[i]);
`endif

    // reset one cycle after an issue: the in-flight tag must vanish
    rand_ops();
    step(4'b0001, 1'b0, rdy);
    bus.req_valid = '0;
    do_reset();
    idle(1);
    chk("rst_flush_rsp", 32'(bus.rsp_valid), 32'd0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/alu_op_arbiter.md
# alu_op_arbiter

Round-robin scheduler sharing one `alu_ip` instance among `NUM_REQ` requesters. Accepts operations over per-requester valid/ready handshakes, issues at most one op per cycle to the ALU through registered outputs, and tracks each op's requester ID through the ALU's fixed latency. Returns each result tagged with its originator. Sits between the requester-side control logic and the single ALU datapath.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: operand/result width, signed.
- `ALU_LAT`, 1: ALU cycles from registered inputs to valid `alu_c`/`alu_z`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `hold` in 1: when 1, no new grants; in-flight ops complete.
- `req_valid` in `NUM_REQ`: per-requester op valid.
- `req_ready` out `NUM_REQ`: per-requester accept, one-hot or zero.
- `req_sel` in `NUM_REQ`x3: ALU opcode per requester.
- `req_a`, `req_b` in `NUM_REQ`x`DATA_W`: signed operands per requester.
- `alu_sel` out 3: registered opcode to ALU.
- `alu_a`, `alu_b` out `DATA_W`: registered operands to ALU.
- `alu_vld` out 1: registered, 1 in the cycle the ALU inputs carry a new op.
- `alu_c` in `DATA_W`: ALU result.
- `alu_z` in 1: ALU zero flag.
- `rsp_valid` out 1: one-cycle result pulse. No backpressure.
- `rsp_id` out `$clog2(NUM_REQ)`: requester ID of the result.
- `rsp_c` out `DATA_W`: registered copy of `alu_c`.
- `rsp_z` out 1: registered copy of `alu_z`.

## Operation
- Arbitration is combinational round-robin over `req_valid`.
  - Search starts at pointer `ptr`; first asserted index wins.
  - `req_ready[g]=1` only for winner `g`, and only when `hold=0`.
- A handshake occurs when `req_valid[g] & req_ready[g]`. On the handshake:
  - `req_sel[g]`, `req_a[g]` and `req_b[g]` are registered onto `alu_*`.
  - `alu_vld` is set to 1.
  - `ptr` becomes `(g+1) mod NUM_REQ`, wrapping from `NUM_REQ-1` to 0.
- No handshake: `alu_vld=0`, `alu_sel/a/b` hold their last values, `ptr` unchanged.
- Tag pipeline: a shift register `ALU_LAT+1` deep, each entry {valid, id}. A new entry is pushed every cycle and carries the handshake outcome.
- On the entry exiting the pipeline:
  - Register `alu_c`/`alu_z` into `rsp_c`/`rsp_z`.
  - Assert `rsp_valid` with the stored id.
  - If the entry's valid bit is 0, `rsp_valid=0` and `rsp_c`/`rsp_z` hold.
- Each result maps to exactly one accepted op, in issue order.
- Requester inputs are not sampled outside the handshake cycle. A requester dropping `req_valid` without a handshake is legal.
- Width rule: operands and results pass through unmodified. No sign extension or truncation in this block.

## Timing
- Reset values: `req_ready` 0, `alu_sel/a/b` 0, `alu_vld` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_c` 0, `rsp_z` 0, `ptr` 0, all tag entries invalid.
- Handshake in cycle T gives:
  - `alu_vld`=1 in T+1.
  - `alu_c` sampled at the end of T+1+`ALU_LAT`.
  - `rsp_valid`=1 in T+2+`ALU_LAT`. With `ALU_LAT=1`, that is T+3.
- Throughput is one op per cycle. With all requesters valid, grants rotate 0,1,2,3,0…
- A `hold` rising edge in cycle T gives no grant in T; ops accepted before T still respond.
- Reset asserted mid-operation discards all in-flight tags. No `rsp_valid` is produced for them after reset releases.
- `req_ready` is combinational from `req_valid`, `ptr` and `hold`. There is no combinational path from `alu_c` to any output.

## Configuration
- `ALU_ARB_STATS_EN` defined adds `grant_cnt` out, `NUM_REQ`x16:
  - One counter per requester.
  - Increments on that requester's handshake.
  - Saturates at 16'hFFFF.
  - Resets to 0 asynchronously.
- Without it, the port and counters are absent. All other behaviour is identical.

## Structure
- Package `alu_arb_pkg` holds:
  - `ALU_SEL_W=3`.
  - Opcode enum `alu_op_e`, with `ALU_ADD=3'b000`.
  - Typedef `arb_tag_t`, a struct {valid, id} with id sized from a package constant `MAX_REQ_W=3`.
- Sub-module `rr_arbiter`, parameterised by `NUM_REQ`:
  - Inputs: request vector, `ptr`, enable.
  - Outputs: one-hot grant and encoded index.
  - Pure combinational.
- Pointer, issue registers, tag pipeline and stats counters live in `alu_op_arbiter`.

## Test plan
- Reset check: hold `rst_n`=0, toggle all inputs → every output 0. Release reset with `req_valid`=4'b0000 → `alu_vld` stays 0.
- Single requester: `req_valid`=4'b0100, `req_sel[2]`=0, `A`=5, `B`=3 in T → `req_ready`=4'b0100 in T, `alu_vld`=1 in T+1, `rsp_valid`=1 in T+3 with `rsp_id`=2 and `rsp_c` equal to the model ALU output.
- Full contention: all four valid for 8 cycles → grant order 0,1,2,3,0,1,2,3. Eight responses arrive in the same order, back-to-back.
- Wrap and skip: `ptr`=3, `req_valid`=4'b0011 → grant 0, then 1, then 0.
- Hold: assert `hold` for 3 cycles during contention → `req_ready`=0 in those cycles. In-flight responses still arrive. `ptr` resumes unchanged.
- Reset mid-flight: issue an op in T, assert `rst_n`=0 in T+1, release in T+2 → no `rsp_valid` in T+3. With `ALU_ARB_STATS_EN`, `grant_cnt` reads 0.
